// File: rtl/alu_arbiter_pkg.sv
// Shared widths, flag bit positions and opcode encodings for the ALU front end.
package alu_arbiter_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned FLG_W  = 5;

  localparam int unsigned FLG_Z  = 4;
  localparam int unsigned FLG_CY = 3;
  localparam int unsigned FLG_S  = 2;
  localparam int unsigned FLG_P  = 1;
  localparam int unsigned FLG_OV = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;

  // Moves (11x) always hold CY/OV so the ALU's undefined carry never lands in flg.
  function automatic logic blocks_cy_ov(input logic [2:0] op, input logic cin);
    return cin | (op[2:1] == OP_MOV[2:1]);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin on last grant, or fixed priority to input 0.
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic last_gnt_q, last_gnt_d;

  always_comb begin
    gnt_o      = '0;
    last_gnt_d = last_gnt_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (RR_EN && !last_gnt_q) ? 2'b10 : 2'b01;
        default: gnt_o = '0;
      endcase
    end
    if (|gnt_o) last_gnt_d = gnt_o[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) last_gnt_q <= 1'b1;
    else       last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for the combinational ALU: grants one op per cycle,
// holds a one-deep response slot and owns the architectural flag register.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic              req0_fwe,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  input  logic              req1_fwe,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_res,
  output logic [FLG_W-1:0]  rsp_flg,
  output logic [FLG_W-1:0]  flg,
  input  logic              flg_wr,
  input  logic [FLG_W-1:0]  flg_wdata,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_arg1,
  output logic [DATA_W-1:0] alu_arg2,
  output logic [FLG_W-1:0]  alu_in_flg,
  output logic              alu_block_cy_ov,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [FLG_W-1:0]  alu_out_flg
);

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
  logic [FLG_W-1:0]  rsp_flg_q, rsp_flg_d;
  logic [FLG_W-1:0]  flg_q, flg_d;

  logic       slot_free, accept, sel, sel_cin, sel_fwe;
  logic [1:0] gnt;

  assign slot_free = !rsp_valid_q || rsp_ready;

  // Reset gates the enable so a request on the reset cycle never sees ready.
  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i ({req1_valid, req0_valid}),
    .en_i  (slot_free && !rst),
    .gnt_o (gnt)
  );

  assign accept     = |gnt;
  assign sel        = gnt[1];
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign alu_opcode      = sel ? req1_op : req0_op;
  assign alu_arg1        = sel ? req1_a  : req0_a;
  assign alu_arg2        = sel ? req1_b  : req0_b;
  assign sel_cin         = sel ? req1_cin : req0_cin;
  assign sel_fwe         = sel ? req1_fwe : req0_fwe;
  assign alu_in_flg      = flg_q;
  assign alu_block_cy_ov = blocks_cy_ov(alu_opcode, sel_cin);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_res_d   = rsp_res_q;
    rsp_flg_d   = rsp_flg_q;
    flg_d       = flg_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = sel;
      rsp_res_d   = alu_res;
      rsp_flg_d   = alu_out_flg;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (flg_wr)                  flg_d = flg_wdata;
    else if (accept && sel_fwe)  flg_d = alu_out_flg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flg_q   <= '0;
      flg_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flg_q   <= rsp_flg_d;
      flg_q       <= flg_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flg   = rsp_flg_q;
  assign flg       = flg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus,
// each driven by a small behavioural ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_cin, req0_fwe;
  logic [2:0]  req0_op;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_cin, req1_fwe;
  logic [2:0]  req1_op;
  logic [15:0] req1_a, req1_b;
  logic        rsp_ready, flg_wr;
  logic [4:0]  flg_wdata;

  logic        rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_blk;
  logic [15:0] rr_rsp_res, rr_arg1, rr_arg2, rr_alu_res;
  logic [4:0]  rr_rsp_flg, rr_flg, rr_in_flg, rr_alu_flg;
  logic [2:0]  rr_opc;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_blk;
  logic [15:0] fp_rsp_res, fp_arg1, fp_arg2, fp_alu_res;
  logic [4:0]  fp_rsp_flg, fp_flg, fp_in_flg, fp_alu_flg;
  logic [2:0]  fp_opc;

  int total = 0;
  int bad   = 0;

  // Stand-in ALU: carry-in only when blocked; arithmetic/move keep P, logic sets even parity.
  function automatic logic [20:0] alu_m(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [4:0] fi,
                                        input logic blk);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, ov, p, cyin;
    cyin = blk ? fi[FLG_CY] : 1'b0;
    c = 1'b0; ov = 1'b0; p = fi[FLG_P]; w = '0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b} + {16'd0, cyin};
        r = w[15:0]; c = w[16]; ov = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b} - {16'd0, cyin};
        r = w[15:0]; c = w[16]; ov = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_AND: begin r = a & b; p = ~^r; end
      OP_OR:  begin r = a | b; p = ~^r; end
      OP_XOR: begin r = a ^ b; p = ~^r; end
      OP_NOT: begin r = ~a;    p = ~^r; end
      default: r = b;
    endcase
    if (blk) begin c = fi[FLG_CY]; ov = fi[FLG_OV]; end
    return {(r == 16'd0), c, r[15], p, ov, r};
  endfunction

  assign {rr_alu_flg, rr_alu_res} = alu_m(rr_opc, rr_arg1, rr_arg2, rr_in_flg, rr_blk);
  assign {fp_alu_flg, fp_alu_res} = alu_m(fp_opc, fp_arg1, fp_arg2, fp_in_flg, fp_blk);

  alu_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_fwe(req0_fwe),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_fwe(req1_fwe),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
    .rsp_res(rr_rsp_res), .rsp_flg(rr_rsp_flg), .flg(rr_flg),
    .flg_wr(flg_wr), .flg_wdata(flg_wdata),
    .alu_opcode(rr_opc), .alu_arg1(rr_arg1), .alu_arg2(rr_arg2),
    .alu_in_flg(rr_in_flg), .alu_block_cy_ov(rr_blk),
    .alu_res(rr_alu_res), .alu_out_flg(rr_alu_flg)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_fwe(req0_fwe),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_fwe(req1_fwe),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_res(fp_rsp_res), .rsp_flg(fp_rsp_flg), .flg(fp_flg),
    .flg_wr(flg_wr), .flg_wdata(flg_wdata),
    .alu_opcode(fp_opc), .alu_arg1(fp_arg1), .alu_arg2(fp_arg2),
    .alu_in_flg(fp_in_flg), .alu_block_cy_ov(fp_blk),
    .alu_res(fp_alu_res), .alu_out_flg(fp_alu_flg)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0; flg_wr = 1'b0; flg_wdata = '0;
    req0_valid = 1'b0; req0_op = OP_ADD; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_fwe = 1'b0;
    req1_valid = 1'b0; req1_op = OP_ADD; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_fwe = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_rsp_valid", {15'd0, rr_rsp_valid}, 16'd0);
    chk("reset_flg", {11'd0, rr_flg}, 16'd0);
    chk("reset_rsp_res", rr_rsp_res, 16'h0000);

    // ADD 0xFFFF + 1 with flag write
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'hFFFF; req0_b = 16'h0001;
    req0_cin = 1'b0; req0_fwe = 1'b1;
    #1;
    chk("add_ready0", {15'd0, rr_req0_ready}, 16'd1);
    step();
    req0_valid = 1'b0;
    chk("add_rsp_valid", {15'd0, rr_rsp_valid}, 16'd1);
    chk("add_rsp_res", rr_rsp_res, 16'h0000);
    chk("add_rsp_flg", {11'd0, rr_rsp_flg}, {11'd0, 5'b11000});
    chk("add_flg", {11'd0, rr_flg}, {11'd0, 5'b11000});
    chk("add_rsp_id", {15'd0, rr_rsp_id}, 16'd0);

    // carry chain, back-to-back with drain
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h0001; req0_b = 16'h0002;
    req0_cin = 1'b1; req0_fwe = 1'b1;
    #1;
    chk("adc_ready0", {15'd0, rr_req0_ready}, 16'd1);
    chk("adc_block", {15'd0, rr_blk}, 16'd1);
    chk("adc_in_flg", {11'd0, rr_in_flg}, {11'd0, 5'b11000});
    step();
    req0_valid = 1'b0; req0_cin = 1'b0;
    chk("adc_rsp_valid", {15'd0, rr_rsp_valid}, 16'd1);
    chk("adc_rsp_res", rr_rsp_res, 16'h0004);
    chk("adc_rsp_flg", {11'd0, rr_rsp_flg}, {11'd0, 5'b01000});
    chk("adc_flg", {11'd0, rr_flg}, {11'd0, 5'b01000});

    // mid-stream reset with a full slot
    rsp_ready = 1'b0; rst = 1'b1;
    step();
    chk("rst_rsp_valid", {15'd0, rr_rsp_valid}, 16'd0);
    chk("rst_flg", {11'd0, rr_flg}, 16'd0);
    chk("rst_rsp_res", rr_rsp_res, 16'h0000);
    rsp_ready = 1'b1; req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h0010;
    req0_b = 16'h0000; req0_fwe = 1'b0;
    #1;
    chk("rst_no_ready", {15'd0, rr_req0_ready}, 16'd0);
    step();
    rst = 1'b0;
    chk("rst_no_accept", {15'd0, rr_rsp_valid}, 16'd0);

    // contention: RR alternates starting at 0, fixed priority stays on 0
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 16'h0020; req1_b = 16'h0003;
    req1_cin = 1'b0; req1_fwe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ready0", {15'd0, rr_req0_ready}, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk("rr_ready1", {15'd0, rr_req1_ready}, (i % 2 == 1) ? 16'd1 : 16'd0);
      chk("fp_ready1", {15'd0, fp_req1_ready}, 16'd0);
      step();
      chk("rr_rsp_id", {15'd0, rr_rsp_id}, (i % 2 == 1) ? 16'd1 : 16'd0);
      chk("rr_rsp_res", rr_rsp_res, (i % 2 == 1) ? 16'h0023 : 16'h0010);
      chk("fp_rsp_id", {15'd0, fp_rsp_id}, 16'd0);
      chk("fp_rsp_res", fp_rsp_res, 16'h0010);
    end

    // backpressure holds the slot, release accepts in the same cycle
    rsp_ready = 1'b0;
    #1;
    chk("bp_ready0", {15'd0, rr_req0_ready}, 16'd0);
    chk("bp_ready1", {15'd0, rr_req1_ready}, 16'd0);
    chk("bp_fp_ready0", {15'd0, fp_req0_ready}, 16'd0);
    step();
    chk("bp_rsp_valid", {15'd0, rr_rsp_valid}, 16'd1);
    chk("bp_rsp_id", {15'd0, rr_rsp_id}, 16'd1);
    chk("bp_rsp_res", rr_rsp_res, 16'h0023);
    rsp_ready = 1'b1;
    #1;
    chk("rel_ready0", {15'd0, rr_req0_ready}, 16'd1);
    chk("rel_ready1", {15'd0, rr_req1_ready}, 16'd0);
    step();
    chk("rel_rsp_id", {15'd0, rr_rsp_id}, 16'd0);
    chk("rel_rsp_res", rr_rsp_res, 16'h0010);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("drain_rsp_valid", {15'd0, rr_rsp_valid}, 16'd0);

    // external flag write beats the AND's flag write
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 16'h0F0F; req0_b = 16'h00F0;
    req0_cin = 1'b0; req0_fwe = 1'b1;
    flg_wr = 1'b1; flg_wdata = 5'b00101;
    step();
    req0_valid = 1'b0; flg_wr = 1'b0;
    chk("col_flg", {11'd0, rr_flg}, {11'd0, 5'b00101});
    chk("col_rsp_flg", {11'd0, rr_rsp_flg}, {11'd0, 5'b10010});
    chk("col_rsp_res", rr_rsp_res, 16'h0000);

    // MOV keeps CY=1
    flg_wr = 1'b1; flg_wdata = 5'b01000;
    step();
    flg_wr = 1'b0;
    chk("wr_flg", {11'd0, rr_flg}, {11'd0, 5'b01000});
    req0_valid = 1'b1; req0_op = OP_MOV; req0_a = 16'h1234; req0_b = 16'h8000;
    req0_cin = 1'b0; req0_fwe = 1'b1;
    #1;
    chk("mov_block", {15'd0, rr_blk}, 16'd1);
    step();
    req0_valid = 1'b0;
    chk("mov_rsp_res", rr_rsp_res, 16'h8000);
    chk("mov_rsp_flg", {11'd0, rr_rsp_flg}, {11'd0, 5'b01100});
    chk("mov_flg", {11'd0, rr_flg}, {11'd0, 5'b01100});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
